lcd_write_engine: RTL

Hardware HD44780-style character-LCD write engine that sits on the peripheral side of the LCD output register. The core, or a bench driver, hands it one byte at a time over a valid/ready handshake. The engine produces the RS/RW/EN/DATA pin waveform with fixed setup, pulse and execution delays. On every reset it first runs an autonomous power-up wait and initialisation sequence.

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_delay_cnt.sv | 44 ++++
 rtl/lcd_write_engine.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
//------------------------------------------------------------------------------
// Module   : lcd_pkg
// Brief    : Shared types, init ROM, opcodes and default timing for the
//            HD44780-style LCD write engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

    localparam int unsigned CNT_W = 20;

    localparam int unsigned DEF_POWERUP_CYC    = 750000;
    localparam int unsigned DEF_SETUP_CYC      = 3;
    localparam int unsigned DEF_EN_PULSE_CYC   = 25;
    localparam int unsigned DEF_CMD_WAIT_CYC   = 2500;
    localparam int unsigned DEF_CLEAR_WAIT_CYC = 82000;

    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;

    // Index 0 is issued first: function set, display on, clear, entry mode.
    localparam logic [3:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    typedef enum logic [2:0] {
        S_PWRUP      = 3'd0,
        S_SETUP      = 3'd1,
        S_PULSE      = 3'd2,
        S_WAIT       = 3'd3,
        S_IDLE       = 3'd4,
        S_POLL_SETUP = 3'd5,
        S_POLL_PULSE = 3'd6
    } lcd_state_e;

    // Clear and home need the long execution time on the panel.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CLEAR) || (data == LCD_HOME));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_delay_cnt.sv
//------------------------------------------------------------------------------
// Module   : lcd_delay_cnt
// Brief    : Loadable down-counter that holds at zero; o_done flags zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_delay_cnt
    import lcd_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_value,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_value = cnt_q;
    assign o_done  = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_write_engine.sv
//------------------------------------------------------------------------------
// Module   : lcd_write_engine
// Brief    : HD44780 pin sequencer: power-up wait, 4-command init, then one
//            byte per valid/ready handshake. Define LCD_BUSY_POLL_EN to
//            replace fixed user-write waits with busy-flag polling.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYC    = DEF_POWERUP_CYC,
    parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
    parameter int unsigned EN_PULSE_CYC   = DEF_EN_PULSE_CYC,
    parameter int unsigned CMD_WAIT_CYC   = DEF_CMD_WAIT_CYC,
    parameter int unsigned CLEAR_WAIT_CYC = DEF_CLEAR_WAIT_CYC
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vld,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_rdy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
`ifdef LCD_BUSY_POLL_EN
    ,
    input  logic       i_lcd_busy,
    output logic       o_lcd_oe
`endif
);

    localparam logic [CNT_W-1:0] C_PWRUP_LD = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_PULSE_LD = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] C_CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] C_CLEAR_LD = CNT_W'(CLEAR_WAIT_CYC - 1);

    lcd_state_e       state_q, state_d;
    logic             on_q, on_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       idx_q, idx_d;
    logic             done_q, done_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;
    logic [CNT_W-1:0] unused_cnt_value;
    logic [CNT_W-1:0] wait_val;
    logic [1:0]       idx_nxt;

`ifdef LCD_BUSY_POLL_EN
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic             poll_timeout;
    logic             in_poll;
`endif

    lcd_delay_cnt u_delay_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (cnt_load),
        .i_load_val (cnt_val),
        .o_value    (unused_cnt_value),
        .o_done     (cnt_done)
    );

    assign wait_val = is_long_cmd(rs_q, data_q) ? C_CLEAR_LD : C_CMD_LD;
    assign idx_nxt  = idx_q + 2'd1;

`ifdef LCD_BUSY_POLL_EN
    assign in_poll      = (state_q == S_POLL_SETUP) || (state_q == S_POLL_PULSE);
    assign poll_timeout = (poll_cnt_q == C_CLEAR_LD);
`endif

    always_comb begin
        state_d  = state_q;
        on_d     = 1'b1;
        rs_d     = rs_q;
        data_d   = data_q;
        idx_d    = idx_q;
        done_d   = done_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
`ifdef LCD_BUSY_POLL_EN
        poll_cnt_d = poll_cnt_q;
`endif

        case (state_q)
            S_PWRUP: begin
                // on_q is low only on the first cycle out of reset: arm the wait.
                if (!on_q) begin
                    cnt_load = 1'b1;
                    cnt_val  = C_PWRUP_LD;
                end else if (cnt_done) begin
                    rs_d     = 1'b0;
                    data_d   = INIT_ROM[0];
                    idx_d    = 2'd0;
                    state_d  = S_SETUP;
                    cnt_load = 1'b1;
                    cnt_val  = C_SETUP_LD;
                end
            end

            S_SETUP: begin
                if (cnt_done) begin
                    state_d  = S_PULSE;
                    cnt_load = 1'b1;
                    cnt_val  = C_PULSE_LD;
                end
            end

            S_PULSE: begin
                if (cnt_done) begin
`ifdef LCD_BUSY_POLL_EN
                    if (done_q) begin
                        state_d    = S_POLL_SETUP;
                        cnt_load   = 1'b1;
                        cnt_val    = C_SETUP_LD;
                        poll_cnt_d = '0;
                    end else begin
                        state_d  = S_WAIT;
                        cnt_load = 1'b1;
                        cnt_val  = wait_val;
                    end
`else
                    state_d  = S_WAIT;
                    cnt_load = 1'b1;
                    cnt_val  = wait_val;
`endif
                end
            end

            S_WAIT: begin
                if (cnt_done) begin
                    if (done_q) begin
                        state_d = S_IDLE;
                    end else if (idx_q != 2'd3) begin
                        idx_d    = idx_nxt;
                        rs_d     = 1'b0;
                        data_d   = INIT_ROM[idx_nxt];
                        state_d  = S_SETUP;
                        cnt_load = 1'b1;
                        cnt_val  = C_SETUP_LD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_IDLE: begin
                if (i_vld) begin
                    rs_d     = i_rs;
                    data_d   = i_data;
                    state_d  = S_SETUP;
                    cnt_load = 1'b1;
                    cnt_val  = C_SETUP_LD;
                end
            end

`ifdef LCD_BUSY_POLL_EN
            S_POLL_SETUP: begin
                poll_cnt_d = poll_cnt_q + CNT_W'(1);
                if (poll_timeout) begin
                    state_d = S_IDLE;
                end else if (cnt_done) begin
                    state_d  = S_POLL_PULSE;
                    cnt_load = 1'b1;
                    cnt_val  = C_PULSE_LD;
                end
            end

            S_POLL_PULSE: begin
                poll_cnt_d = poll_cnt_q + CNT_W'(1);
                if (poll_timeout) begin
                    state_d = S_IDLE;
                end else if (cnt_done) begin
                    // DB7 is sampled on the last EN-high cycle.
                    if (!i_lcd_busy) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_POLL_SETUP;
                        cnt_load = 1'b1;
                        cnt_val  = C_SETUP_LD;
                    end
                end
            end
`endif

            default: begin
                state_d = S_PWRUP;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_PWRUP;
            on_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

`ifdef LCD_BUSY_POLL_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
        end
    end
`endif

    // EN decodes straight from the state flop so reset kills it asynchronously.
    assign o_rdy       = (state_q == S_IDLE);
    assign o_init_done = done_q;
    assign o_lcd_on    = on_q;
    assign o_lcd_data  = data_q;

`ifdef LCD_BUSY_POLL_EN
    assign o_lcd_en = (state_q == S_PULSE) || (state_q == S_POLL_PULSE);
    assign o_lcd_rs = in_poll ? 1'b0 : rs_q;
    assign o_lcd_rw = in_poll;
    assign o_lcd_oe = !in_poll;
`else
    assign o_lcd_en = (state_q == S_PULSE);
    assign o_lcd_rs = rs_q;
    assign o_lcd_rw = 1'b0;
`endif

endmodule

`default_nettype wire
